// File: rtl/gpu_inst_fifo.sv
// gpu_inst_fifo: show-ahead instruction FIFO feeding the 2D GPU command path.
// The oldest entry is always visible on r_data while empty is low; a single
// r_enable pulse pops it. Occupancy is an explicit register, and sticky
// overflow/underflow flags help during bring-up.
// Optional feature: define GPU_INST_FIFO_WATERMARK_EN to build a registered
// almost_full output; otherwise almost_full is tied low.
module gpu_inst_fifo #(
  parameter int DATA_W    = 82,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_enable,
  input  logic [DATA_W-1:0]        w_data,
  output logic                     full,
  input  logic                     r_enable,
  output logic [DATA_W-1:0]        r_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              isFull, isEmpty;
  logic              pushOk, popOk;

  // Status is decoded only from the registered count, so it never glitches.
  assign isFull  = (count_q == FULL_COUNT);
  assign isEmpty = (count_q == '0);

  // A push into a full FIFO is allowed when the head is leaving the same cycle.
  assign pushOk = w_enable & (~isFull | r_enable);
  assign popOk  = r_enable & ~isEmpty;

  // Pointer and occupancy next-state; pointers wrap by natural overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (pushOk) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (popOk) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({pushOk, popOk})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (w_enable & isFull & ~r_enable) begin
      overflow_d = 1'b1;
    end
    if (r_enable & isEmpty) begin
      underflow_d = 1'b1;
    end
  end

  // Control state register; reset discards every entry and beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is not reset; only accepted pushes outside reset write it.
  always_ff @(posedge clk) begin
    if (!rst && pushOk) begin
      mem_q[wptr_q] <= w_data;
    end
  end

  // Show-ahead head read from registered storage; zeros while empty.
  assign r_data = isEmpty ? '0 : mem_q[rptr_q];

  assign full      = isFull;
  assign empty     = isEmpty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef GPU_INST_FIFO_WATERMARK_EN
  logic almostFull_q, almostFull_d;

  // Watermark tracks the occupancy that the next edge will produce.
  always_comb begin
    almostFull_d = (count_d >= CW'(DEPTH - AF_MARGIN));
  end

  // Register the watermark alongside count so both change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      almostFull_q <= 1'b0;
    end else begin
      almostFull_q <= almostFull_d;
    end
  end

  assign almost_full = almostFull_q;
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_inst_fifo.sv
// tb_gpu_inst_fifo: randomized scoreboard bench for gpu_inst_fifo.
// Stimulus pushes expected words into a queue; a negedge monitor checks
// status against a queue-level occupancy model and pops/compares data
// whenever the DUT performs a pop.
module tb_gpu_inst_fifo;

  localparam int DATA_W    = 82;
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              w_enable = 1'b0;
  logic [DATA_W-1:0] w_data = '0;
  logic              full;
  logic              r_enable = 1'b0;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic [CW-1:0]     count;
  logic              almost_full;
  logic              overflow;
  logic              underflow;
  logic              clear_err = 1'b0;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  logic [DATA_W-1:0] expQ[$];
  int mCount = 0;
  bit mOver  = 1'b0;
  bit mUnder = 1'b0;

  always #5 clk = ~clk;

  gpu_inst_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_MARGIN(AF_MARGIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_enable   (w_enable),
    .w_data     (w_data),
    .full       (full),
    .r_enable   (r_enable),
    .r_data     (r_data),
    .empty      (empty),
    .count      (count),
    .almost_full(almost_full),
    .overflow   (overflow),
    .underflow  (underflow),
    .clear_err  (clear_err)
  );

  // One comparison: bump the counters and report any difference.
  task automatic checkOutput(input string name, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic bit expAlmostFull(input int c);
`ifdef GPU_INST_FIFO_WATERMARK_EN
    return c >= DEPTH - AF_MARGIN;
`else
    return (c < 0);
`endif
  endfunction

  // Drive one cycle of inputs, record accepted pushes, then commit the model.
  task automatic applyStimulus(input bit we, input logic [DATA_W-1:0] wd,
                               input bit re, input bit clr, input bit rs);
    bit pushAcc, popAcc, setOver, setUnder;
    w_enable  = we;
    w_data    = wd;
    r_enable  = re;
    clear_err = clr;
    rst       = rs;
    pushAcc  = we && (mCount < DEPTH || re);
    popAcc   = re && (mCount > 0);
    setOver  = we && (mCount == DEPTH) && !re;
    setUnder = re && (mCount == 0);
    if (!rs && pushAcc) expQ.push_back(wd);
    @(posedge clk);
    #1;
    if (rs) begin
      mCount = 0;
      mOver  = 1'b0;
      mUnder = 1'b0;
      expQ.delete();
      armed  = 1'b1;
    end else begin
      mCount = mCount + (pushAcc ? 1 : 0) - (popAcc ? 1 : 0);
      mOver  = setOver  ? 1'b1 : (clr ? 1'b0 : mOver);
      mUnder = setUnder ? 1'b1 : (clr ? 1'b0 : mUnder);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: status versus model every cycle, data whenever the DUT pops.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        checkOutput("count", DATA_W'(count), DATA_W'(mCount));
        checkOutput("empty", DATA_W'(empty), DATA_W'(mCount == 0));
        checkOutput("full", DATA_W'(full), DATA_W'(mCount == DEPTH));
        checkOutput("overflow", DATA_W'(overflow), DATA_W'(mOver));
        checkOutput("underflow", DATA_W'(underflow), DATA_W'(mUnder));
        checkOutput("almost_full", DATA_W'(almost_full), DATA_W'(expAlmostFull(mCount)));
        if (mCount == 0) checkOutput("r_data_zero", r_data, '0);
        if (r_enable && !empty && !rst) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL pop_data: got 0x%0h expected no pending entry", r_data);
          end else begin
            checkOutput("r_data", r_data, expQ.pop_front());
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [DATA_W-1:0] rnd;
    int wPct, rPct;
    $display("[TB] reset");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);

    $display("[TB] fill and drain");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);

    $display("[TB] wrap fill, full push+pop, overflow");
    for (int i = 9; i <= 16; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'(8'hAA), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'(8'hBB), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] underflow and clear");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, DATA_W'(8'h55), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] watermark");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, DATA_W'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);

    $display("[TB] mid-operation reset");
    applyStimulus(1'b1, DATA_W'(32'hDEAD), 1'b0, 1'b0, 1'b1);
    idle(2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DATA_W'(32'h200 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'(32'hBEEF), 1'b1, 1'b0, 1'b1);
    idle(1);
    applyStimulus(1'b1, DATA_W'(32'h300), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      wPct = ((i / 100) % 2 == 0) ? 70 : 35;
      rPct = 100 - wPct;
      rnd  = DATA_W'({$urandom, $urandom, $urandom});
      applyStimulus($urandom_range(0, 99) < wPct, rnd,
                    $urandom_range(0, 99) < rPct,
                    $urandom_range(0, 99) < 4,
                    $urandom_range(0, 199) == 0);
    end
    while (mCount > 0) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
